// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and widths for the instruction-fetch responder.
package imem_fetch_responder_pkg;
  localparam int unsigned PC_W       = 8;
  localparam int unsigned DEF_ADDR_W = PC_W;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;
endpackage

// File: rtl/imem_wait_counter.sv
// Loadable 4-bit down-counter that stops at zero; counts memory wait states.
module imem_wait_counter
  import imem_fetch_responder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: multi-cycle read of a synchronous instruction memory.
// Optional last-address hit shortcut enabled by defining IMEM_LASTHIT_EN.
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned DEPTH       = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [ADDR_W:0]    DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]   WS_L    = CNT_W'(WAIT_STATES);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic              in_range;
  logic              accept;
  logic              capture;
  logic              hit;
  logic              cnt_zero;

  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign mem_addr = addr_q;

  imem_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (WS_L),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ack      = 1'b0;
    mem_rd   = 1'b0;
    accept   = 1'b0;
    capture  = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (req) begin
          accept   = 1'b1;
          state_nx = hit ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        mem_rd = in_range;
        if (cnt_zero) begin
          capture  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        ack      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      if (accept) addr_q <= addr;
      if (capture) begin
        rdata <= in_range ? mem_rdata : '0;
        err   <= ~in_range;
      end
    end
  end

`ifdef IMEM_LASTHIT_EN
  logic [ADDR_W-1:0] tag_q;
  logic              tag_valid;

  // A hit implies the last capture succeeded, so rdata/err already hold the answer.
  assign hit = tag_valid && (addr == tag_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q     <= '0;
      tag_valid <= 1'b0;
    end else if (capture) begin
      tag_q     <= addr_q;
      tag_valid <= in_range;
    end
  end
`else
  assign hit = 1'b0;
`endif
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Randomized self-checking bench for imem_fetch_responder against a transaction-level model.
module tb_imem_fetch_responder;
  localparam int unsigned WS_A    = 2;
  localparam int unsigned DEPTH_A = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_a, ack_a, err_a, busy_a, mem_rd_a;
  logic [7:0]  addr_a, mem_addr_a;
  logic [15:0] rdata_a, mem_rdata_a;

  logic        req_b, ack_b, err_b, busy_b, mem_rd_b;
  logic [7:0]  addr_b, mem_addr_b;
  logic [15:0] rdata_b, mem_rdata_b;

  logic [15:0] mem [0:255];
  logic [15:0] junk = 16'h5a5b;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state: last-hit tag and the last captured response.
  bit          tag_v = 1'b0;
  logic [7:0]  tag = '0;
  logic [15:0] last_rdata = '0;
  bit          last_err = 1'b0;

  always #5 clk = ~clk;
  always @(negedge clk) junk = 16'($urandom) | 16'h0001;

  assign mem_rdata_a = mem_rd_a ? mem[mem_addr_a] : junk;
  assign mem_rdata_b = mem_rd_b ? mem[mem_addr_b] : junk;

  imem_fetch_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(WS_A), .DEPTH(DEPTH_A)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .addr(addr_a), .ack(ack_a), .rdata(rdata_a),
    .err(err_a), .busy(busy_a), .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_rdata(mem_rdata_a));

  imem_fetch_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(0), .DEPTH(256)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .addr(addr_b), .ack(ack_b), .rdata(rdata_b),
    .err(err_b), .busy(busy_b), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_rdata(mem_rdata_b));

  task automatic check_eq(input string tag_s, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag_s, got, exp, $time);
    end
  endtask

  // Called at a negedge with dut_a idle; returns at a negedge with dut_a idle again.
  task automatic fetch_a(input logic [7:0] a, input bit hold);
    bit          inr;
    bit          hit;
    int unsigned n_acc;
    inr = (a < DEPTH_A);
    hit = 1'b0;
`ifdef IMEM_LASTHIT_EN
    hit = tag_v && (a == tag);
`endif
    n_acc = hit ? 0 : WS_A + 1;
    req_a  = 1'b1;
    addr_a = a;
    @(posedge clk);
    for (int unsigned k = 0; k < n_acc; k++) begin
      @(negedge clk);
      check_eq("acc_busy", busy_a, 1);
      check_eq("acc_mem_rd", mem_rd_a, inr);
      check_eq("acc_ack", ack_a, 0);
      check_eq("acc_mem_addr", mem_addr_a, a);
      if (k == 0) begin
        addr_a = a ^ 8'h30;
        if (!hold) req_a = 1'b0;
      end
    end
    if (!hit) begin
      last_rdata = inr ? mem[a] : 16'h0000;
      last_err   = !inr;
      tag_v      = inr;
      tag        = a;
    end
    @(negedge clk);
    check_eq("done_ack", ack_a, 1);
    check_eq("done_rdata", rdata_a, last_rdata);
    check_eq("done_err", err_a, last_err);
    check_eq("done_busy", busy_a, 1);
    check_eq("done_mem_rd", mem_rd_a, 0);
    req_a  = 1'b0;
    addr_a = 8'($urandom);
    @(negedge clk);
    check_eq("idle_ack", ack_a, 0);
    check_eq("idle_busy", busy_a, 0);
  endtask

  initial begin
    logic [7:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h05] = 16'hA3C1;
    req_a = 1'b0; addr_a = '0;
    req_b = 1'b0; addr_b = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_ack", ack_a, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_mem_rd", mem_rd_a, 0);
    check_eq("rst_err", err_a, 0);
    check_eq("rst_rdata", rdata_a, 0);
    check_eq("rst_mem_addr", mem_addr_a, 0);
    check_eq("rst_b_busy", busy_b, 0);
    reset = 1'b1;
    @(negedge clk);

    fetch_a(8'h05, 1'b0);
    fetch_a(8'h05, 1'b1);
    fetch_a(8'h90, 1'b0);
    fetch_a(8'h10, 1'b0);

    // WAIT_STATES=0 instance, req held high across two fetches
    req_b = 1'b1; addr_b = 8'h00;
    @(negedge clk);
    check_eq("b0_busy", busy_b, 1);
    check_eq("b0_mem_rd", mem_rd_b, 1);
    check_eq("b0_ack", ack_b, 0);
    check_eq("b0_mem_addr", mem_addr_b, 8'h00);
    addr_b = 8'h01;
    @(negedge clk);
    check_eq("b0_done_ack", ack_b, 1);
    check_eq("b0_rdata", rdata_b, mem[0]);
    check_eq("b0_err", err_b, 0);
    @(negedge clk);
    check_eq("b_gap_busy", busy_b, 0);
    check_eq("b_gap_ack", ack_b, 0);
    @(negedge clk);
    check_eq("b1_busy", busy_b, 1);
    check_eq("b1_mem_addr", mem_addr_b, 8'h01);
    check_eq("b1_mem_rd", mem_rd_b, 1);
    @(negedge clk);
    check_eq("b1_done_ack", ack_b, 1);
    check_eq("b1_rdata", rdata_b, mem[1]);
    req_b = 1'b0;
    @(negedge clk);
    check_eq("b1_idle_busy", busy_b, 0);

    // asynchronous reset in the middle of an access
    req_a = 1'b1; addr_a = 8'h05;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("mrst_ack", ack_a, 0);
    check_eq("mrst_busy", busy_a, 0);
    check_eq("mrst_rdata", rdata_a, 0);
    check_eq("mrst_err", err_a, 0);
    check_eq("mrst_mem_rd", mem_rd_a, 0);
    check_eq("mrst_mem_addr", mem_addr_a, 0);
    req_a = 1'b0;
    tag_v = 1'b0; last_rdata = '0; last_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy", busy_a, 0);
    check_eq("post_rst_ack", ack_a, 0);
    fetch_a(8'h05, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       a = 8'h05;
        1:       a = 8'h10;
        2:       a = 8'h7F;
        3:       a = 8'h80;
        default: a = 8'($urandom);
      endcase
      fetch_a(a, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_eq("gap_busy", busy_a, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
